// File: rtl/dma_pkg.sv
// Shared types and helpers for the single-channel AXI4-Lite DMA engine.
// Holds the FSM state encoding, bus width constants and strobe helper.
package dma_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  // Byte remainder of the transfer length -> strobe of the final beat.
  function automatic logic [AXI_STRB_W-1:0] strb_mask(input logic [1:0] rem);
    logic [AXI_STRB_W-1:0] m;
    case (rem)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// Synchronous word FIFO between the read and write phases of the DMA.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module dma_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA: AXI4-Lite reads fill a FIFO,
// AXI4-Lite writes drain it, one outstanding transaction at a time.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic [31:0]             length,
  input  logic [ADDR_WIDTH-1:0]   destination_address,
  input  logic [ADDR_WIDTH-1:0]   source_address,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic                    done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [32:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [1:0] rem_q, rem_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic bready_q, bready_d, done_q, done_d;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic [32:0] beats;
  logic aw_hs, w_hs, last_beat, unused_bresp;

  assign unused_bresp = BRESP;
  assign beats = ({1'b0, length} + 33'd3) >> 2;
  assign aw_hs = awvalid_q && AWREADY;
  assign w_hs  = wvalid_q && WREADY;
  assign last_beat = (wr_left_q == 33'd1) && (rem_q != 2'd0);

  dma_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(RDATA),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    rem_d     = rem_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          src_d     = source_address;
          dst_d     = destination_address;
          rd_left_d = beats;
          wr_left_d = beats;
          rem_d     = length[1:0];
          state_d   = (length == 32'd0) ? DONE : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (RVALID && rready_q) begin
          fifo_push = 1'b1;
          src_d     = src_q + ADDR_WIDTH'(4);
          rd_left_d = rd_left_q - 33'd1;
          // Turn around to writes once the FIFO fills with this push.
          if (rd_left_d != 33'd0 && !fifo_full &&
              fifo_count != CNT_W'(FIFO_DEPTH - 1))
            state_d = RD_ADDR;
          else
            state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          fifo_pop  = 1'b1;
          dst_d     = dst_q + ADDR_WIDTH'(4);
          wr_left_d = wr_left_q - 33'd1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID && bready_q) begin
          if (!fifo_empty)              state_d = WR_REQ;
          else if (rd_left_q != 33'd0)  state_d = RD_ADDR;
          else                          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == RD_ADDR);
    rready_d  = (state_d == RD_DATA);
    awvalid_d = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d  = (state_d == WR_REQ) && !w_done_d;
    bready_d  = (state_d == WR_RESP);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      rem_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      rem_q     <= rem_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
    end
  end

  assign ARADDR  = src_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign AWADDR  = dst_q;
  assign AWVALID = awvalid_q;
  assign WVALID  = wvalid_q;
  assign WDATA   = wvalid_q ? fifo_head : '0;
  assign WSTRB   = !wvalid_q ? '0 : (last_beat ? strb_mask(rem_q) : '1);
  assign BREADY  = bready_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a reactive AXI4-Lite memory model.
// Expected addresses, data and strobes are computed from the test vectors.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] length = '0;
  logic [31:0] destination_address = '0;
  logic [31:0] source_address = '0;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        BRESP = 1'b0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic        done;

  always #5 clk = ~clk;

  dma_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .length(length),
    .destination_address(destination_address),
    .source_address(source_address),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .done(done)
  );

  int checks = 0;
  int errors = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int done_cnt = 0, unstable = 0;
  logic [31:0] r_addr = '0;
  logic ar_hold = 0, aw_hold = 0, w_hold = 0;
  logic [31:0] ar_prev = '0, aw_prev = '0, wd_prev = '0;
  logic [3:0] ws_prev = '0;
  logic [31:0] ar_log[$];
  logic [31:0] aw_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  ws_log[$];
  byte         ev_log[$];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [3:0] exp_strb(input int k, input int n,
                                          input logic [31:0] len);
    if (k != n - 1) return 4'hF;
    case (len[1:0])
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'hF;
    endcase
  endfunction

  // Memory-side model: inputs change on the falling edge only.
  always @(negedge clk) begin
    if (!rst) begin
      ARREADY = 0; RVALID = 0; RDATA = 0; AWREADY = 0;
      WREADY = 0; BVALID = 0; BRESP = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_hold = 0; aw_hold = 0; w_hold = 0;
    end else begin
      if (ar_hold && (!ARVALID || ARADDR !== ar_prev)) unstable++;
      if (aw_hold && (!AWVALID || AWADDR !== aw_prev)) unstable++;
      if (w_hold && (!WVALID || WDATA !== wd_prev || WSTRB !== ws_prev))
        unstable++;
      if (done) done_cnt++;
      ARREADY = 0;
      if (ARVALID) begin
        if (ar_cnt >= ar_dly) begin
          ARREADY = 1; ar_cnt = 0; r_addr = ARADDR;
          ar_log.push_back(ARADDR); ev_log.push_back(8'h52);
        end else ar_cnt++;
      end else ar_cnt = 0;
      RVALID = 0; RDATA = 0;
      if (RREADY) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1; RDATA = rd_word(r_addr); r_cnt = 0;
        end else r_cnt++;
      end else r_cnt = 0;
      AWREADY = 0;
      if (AWVALID) begin
        if (aw_cnt >= aw_dly) begin
          AWREADY = 1; aw_cnt = 0;
          aw_log.push_back(AWADDR); ev_log.push_back(8'h57);
        end else aw_cnt++;
      end else aw_cnt = 0;
      WREADY = 0;
      if (WVALID) begin
        if (w_cnt >= w_dly) begin
          WREADY = 1; w_cnt = 0;
          wd_log.push_back(WDATA); ws_log.push_back(WSTRB);
        end else w_cnt++;
      end else w_cnt = 0;
      BVALID = 0;
      if (BREADY) begin
        if (b_cnt >= b_dly) begin
          BVALID = 1; b_cnt = 0;
        end else b_cnt++;
      end else b_cnt = 0;
      ar_hold = ARVALID && !ARREADY; ar_prev = ARADDR;
      aw_hold = AWVALID && !AWREADY; aw_prev = AWADDR;
      w_hold = WVALID && !WREADY; wd_prev = WDATA; ws_prev = WSTRB;
    end
  end

  task automatic clear_logs();
    ar_log.delete(); aw_log.delete(); wd_log.delete();
    ws_log.delete(); ev_log.delete();
    done_cnt = 0; unstable = 0;
  endtask

  task automatic start(input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] len);
    @(negedge clk);
    source_address = src; destination_address = dst; length = len;
    trigger = 1;
    @(negedge clk);
    trigger = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      $display("FAIL done_timeout got=0 exp=1 after %0d cycles", n);
      errors++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, done} !== 6'b0) begin
      $display("FAIL reset_ctl got=%b exp=000000",
               {ARVALID, RREADY, AWVALID, WVALID, BREADY, done});
      errors++;
    end
    checks++;
    if (ARADDR !== 32'h0 || AWADDR !== 32'h0) begin
      $display("FAIL reset_addr got=%h/%h exp=0/0", ARADDR, AWADDR);
      errors++;
    end
    checks++;
    if (WDATA !== 32'h0 || WSTRB !== 4'h0) begin
      $display("FAIL reset_wdata got=%h/%h exp=0/0", WDATA, WSTRB);
      errors++;
    end
    #2 rst = 1;
  endtask

  task automatic test_basic();
    clear_logs();
    start(32'h1, 32'hD, 32'd5);
    wait_done(200);
    checks++;
    if (ar_log.size() !== 2 || ar_log[0] !== 32'h1 || ar_log[1] !== 32'h5) begin
      $display("FAIL basic_araddr got n=%0d %h %h exp 2 1 5",
               ar_log.size(), ar_log[0], ar_log[1]);
      errors++;
    end
    checks++;
    if (aw_log.size() !== 2 || aw_log[0] !== 32'hD || aw_log[1] !== 32'h11) begin
      $display("FAIL basic_awaddr got n=%0d %h %h exp 2 d 11",
               aw_log.size(), aw_log[0], aw_log[1]);
      errors++;
    end
    checks++;
    if (wd_log.size() !== 2 || wd_log[0] !== rd_word(32'h1) ||
        wd_log[1] !== rd_word(32'h5)) begin
      $display("FAIL basic_wdata got %h %h exp %h %h", wd_log[0],
               wd_log[1], rd_word(32'h1), rd_word(32'h5));
      errors++;
    end
    checks++;
    if (ws_log[0] !== 4'hF || ws_log[1] !== 4'h1) begin
      $display("FAIL basic_wstrb got %h %h exp f 1", ws_log[0], ws_log[1]);
      errors++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL basic_done got=%0d exp=1", done_cnt);
      errors++;
    end
  endtask

  task automatic test_aligned();
    int bad = 0;
    clear_logs();
    start(32'h100, 32'h200, 32'd16);
    wait_done(200);
    for (int k = 0; k < 4; k++) begin
      if (ar_log[k] !== 32'h100 + 4 * k) bad++;
      if (aw_log[k] !== 32'h200 + 4 * k) bad++;
      if (wd_log[k] !== rd_word(32'h100 + 4 * k)) bad++;
      if (ws_log[k] !== 4'hF) bad++;
    end
    checks++;
    if (bad !== 0 || ar_log.size() !== 4 || aw_log.size() !== 4) begin
      $display("FAIL aligned_beats got bad=%0d n=%0d/%0d exp 0 4/4",
               bad, ar_log.size(), aw_log.size());
      errors++;
    end
    checks++;
    if (ev_log.size() !== 8 || ev_log[3] !== 8'h52 || ev_log[4] !== 8'h57) begin
      $display("FAIL aligned_order got n=%0d exp 4 reads then 4 writes",
               ev_log.size());
      errors++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL aligned_done got=%0d exp=1", done_cnt);
      errors++;
    end
  endtask

  task automatic test_zero();
    clear_logs();
    start(32'h300, 32'h400, 32'd0);
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL zero_done_pulse got=%b exp=1", done);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL zero_done_width got=%b exp=0", done);
      errors++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ar_log.size() !== 0 || aw_log.size() !== 0 || done_cnt !== 1) begin
      $display("FAIL zero_activity got ar=%0d aw=%0d done=%0d exp 0 0 1",
               ar_log.size(), aw_log.size(), done_cnt);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_logs();
    ar_dly = 3; r_dly = 3; aw_dly = 3; w_dly = 1; b_dly = 3;
    start(32'h40, 32'h80, 32'd12);
    wait_done(400);
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    for (int k = 0; k < 3; k++) begin
      if (ar_log[k] !== 32'h40 + 4 * k) bad++;
      if (aw_log[k] !== 32'h80 + 4 * k) bad++;
      if (wd_log[k] !== rd_word(32'h40 + 4 * k)) bad++;
      if (ws_log[k] !== 4'hF) bad++;
    end
    checks++;
    if (bad !== 0 || ar_log.size() !== 3 || aw_log.size() !== 3 ||
        wd_log.size() !== 3) begin
      $display("FAIL bp_beats got bad=%0d n=%0d/%0d/%0d exp 0 3/3/3", bad,
               ar_log.size(), aw_log.size(), wd_log.size());
      errors++;
    end
    checks++;
    if (unstable !== 0) begin
      $display("FAIL bp_stable got=%0d exp=0", unstable);
      errors++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL bp_done got=%0d exp=1", done_cnt);
      errors++;
    end
  endtask

  task automatic test_chunking();
    int bad = 0, ord = 0;
    logic [31:0] src = 32'hFFFF_FFC0;
    logic [31:0] dst = 32'h3000;
    logic [31:0] len = 32'd76;
    byte exp_ev[$];
    clear_logs();
    for (int i = 0; i < 16; i++) exp_ev.push_back(8'h52);
    for (int i = 0; i < 16; i++) exp_ev.push_back(8'h57);
    for (int i = 0; i < 3; i++)  exp_ev.push_back(8'h52);
    for (int i = 0; i < 3; i++)  exp_ev.push_back(8'h57);
    start(src, dst, len);
    wait_done(800);
    for (int k = 0; k < 19; k++) begin
      if (ar_log[k] !== src + 32'(4 * k)) bad++;
      if (aw_log[k] !== dst + 32'(4 * k)) bad++;
      if (wd_log[k] !== rd_word(src + 32'(4 * k))) bad++;
      if (ws_log[k] !== exp_strb(k, 19, len)) bad++;
    end
    for (int i = 0; i < 38; i++)
      if (ev_log[i] !== exp_ev[i]) ord++;
    checks++;
    if (bad !== 0 || ar_log.size() !== 19 || aw_log.size() !== 19) begin
      $display("FAIL chunk_beats got bad=%0d n=%0d/%0d exp 0 19/19",
               bad, ar_log.size(), aw_log.size());
      errors++;
    end
    checks++;
    if (ord !== 0 || ev_log.size() !== 38) begin
      $display("FAIL chunk_order got bad=%0d n=%0d exp 0 38",
               ord, ev_log.size());
      errors++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL chunk_done got=%0d exp=1", done_cnt);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    clear_logs();
    start(32'h700, 32'h800, 32'd32);
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, done} !== 6'b0 ||
        ARADDR !== 32'h0 || AWADDR !== 32'h0 || WDATA !== 32'h0 ||
        WSTRB !== 4'h0) begin
      $display("FAIL midreset_outputs got ctl=%b ar=%h aw=%h wd=%h ws=%h exp 0",
               {ARVALID, RREADY, AWVALID, WVALID, BREADY, done},
               ARADDR, AWADDR, WDATA, WSTRB);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    clear_logs();
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || ar_log.size() !== 0 || aw_log.size() !== 0) begin
      $display("FAIL midreset_quiet got done=%0d ar=%0d aw=%0d exp 0 0 0",
               done_cnt, ar_log.size(), aw_log.size());
      errors++;
    end
    start(32'h1000, 32'h2000, 32'd10);
    wait_done(200);
    for (int k = 0; k < 3; k++) begin
      if (ar_log[k] !== 32'h1000 + 4 * k) bad++;
      if (aw_log[k] !== 32'h2000 + 4 * k) bad++;
      if (wd_log[k] !== rd_word(32'h1000 + 4 * k)) bad++;
      if (ws_log[k] !== exp_strb(k, 3, 32'd10)) bad++;
    end
    checks++;
    if (bad !== 0 || ar_log.size() !== 3 || aw_log.size() !== 3 ||
        done_cnt !== 1) begin
      $display("FAIL midreset_rerun got bad=%0d n=%0d/%0d done=%0d exp 0 3/3 1",
               bad, ar_log.size(), aw_log.size(), done_cnt);
      errors++;
    end
  endtask

  task automatic test_retrigger();
    clear_logs();
    start(32'h500, 32'h600, 32'd8);
    repeat (2) @(negedge clk);
    source_address = 32'h900; destination_address = 32'hA00;
    length = 32'd40; trigger = 1;
    @(negedge clk);
    trigger = 0;
    wait_done(200);
    repeat (6) @(negedge clk);
    checks++;
    if (ar_log.size() !== 2 || ar_log[0] !== 32'h500 || ar_log[1] !== 32'h504) begin
      $display("FAIL retrig_reads got n=%0d %h %h exp 2 500 504",
               ar_log.size(), ar_log[0], ar_log[1]);
      errors++;
    end
    checks++;
    if (aw_log.size() !== 2 || aw_log[0] !== 32'h600 || done_cnt !== 1) begin
      $display("FAIL retrig_writes got n=%0d %h done=%0d exp 2 600 1",
               aw_log.size(), aw_log[0], done_cnt);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aligned();
    test_zero();
    test_backpressure();
    test_chunking();
    test_reset_mid();
    test_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
